// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states,
// data-length encodings and the frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP1   = 3'd4,
    ST_STOP2   = 3'd5,
    ST_BRKWAIT = 3'd6
  } uart_rx_state_e;

  localparam logic [1:0] UART_BITS_5 = 2'd0;
  localparam logic [1:0] UART_BITS_6 = 2'd1;
  localparam logic [1:0] UART_BITS_7 = 2'd2;
  localparam logic [1:0] UART_BITS_8 = 2'd3;

  // Start + data + optional parity + one or two stop bits.
  function automatic logic [3:0] uart_frame_bits(input logic [1:0] bits,
                                                 input logic       par,
                                                 input logic       stop2);
    return 4'd7 + {2'b00, bits} + {3'b000, par} + {3'b000, stop2};
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: divisor counter plus in-bit tick index, with
// strobes on the three majority-vote sample points and on the bit boundary.
module uart_baud_tick #(
  parameter int OVS   = 16,
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             samp_lo,
  output logic             samp_mid,
  output logic             samp_hi,
  output logic             bit_end
);

  localparam int IDX_W = $clog2(OVS);
  localparam logic [IDX_W-1:0] IDX_LO   = IDX_W'(OVS / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVS / 2);
  localparam logic [IDX_W-1:0] IDX_HI   = IDX_W'(OVS / 2 + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVS - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;

  // >= rather than == so a divisor lowered while idle cannot strand the counter.
  assign tick     = (cnt_q >= div);
  assign samp_lo  = tick && (idx_q == IDX_LO);
  assign samp_mid = tick && (idx_q == IDX_MID);
  assign samp_hi  = tick && (idx_q == IDX_HI);
  assign bit_end  = tick && (idx_q == IDX_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with glitch-rejecting start detection, break and
// overrun reporting. Define UART_RX_TIMEOUT_EN to build the character timeout.
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int OVS           = 16,
  parameter int DIV_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [1:0]       cfg_bits_i,
  input  logic             cfg_parity_en_i,
  input  logic             cfg_parity_odd_i,
  input  logic             cfg_stop2_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             break_o,
  output logic             overrun_o,
  output logic             timeout_o,
  output logic             busy_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev_q, start_edge;
  uart_rx_state_e         state_q;
  logic [DIV_W-1:0]       div_q, div_eff;
  logic [1:0]             bits_q;
  logic                   par_en_q, par_odd_q, stop2_q;
  logic                   tick, samp_lo, samp_mid, samp_hi, bit_end;
  logic                   samp_a_q, samp_b_q, maj;
  logic [2:0]             bit_cnt_q, last_bit;
  logic [7:0]             shift_q;
  logic                   par_bit_q, par_err_q, frm_err_q, brk_q, comp_q;
  logic                   unused_sig;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = (state_q == ST_IDLE) && rx_prev_q && !rx_s;
  assign div_eff    = (state_q == ST_IDLE) ? cfg_div_i : div_q;
  assign maj        = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);
  assign busy_o     = (state_q != ST_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking so every stage takes its neighbour's old value.
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q     <= '0;
      bits_q    <= UART_BITS_5;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (start_edge) begin
      div_q     <= cfg_div_i;
      bits_q    <= cfg_bits_i;
      par_en_q  <= cfg_parity_en_i;
      par_odd_q <= cfg_parity_odd_i;
      stop2_q   <= cfg_stop2_i;
    end
  end

  uart_baud_tick #(.OVS(OVS), .DIV_W(DIV_W)) u_tick (
    .CLK      (CLK),
    .RST      (RST),
    .restart  (start_edge),
    .div      (div_eff),
    .tick     (tick),
    .samp_lo  (samp_lo),
    .samp_mid (samp_mid),
    .samp_hi  (samp_hi),
    .bit_end  (bit_end)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      if (samp_lo)  samp_a_q <= rx_s;
      if (samp_mid) samp_b_q <= rx_s;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves last_bit unassigned (no latch).
    last_bit = 3'd7;
    case (bits_q)
      UART_BITS_5: last_bit = 3'd4;
      UART_BITS_6: last_bit = 3'd5;
      UART_BITS_7: last_bit = 3'd6;
      UART_BITS_8: last_bit = 3'd7;
      default:     last_bit = 3'd7;
    endcase
  end

  // Every decision is taken at the third vote sample (samp_hi) of the bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      brk_q     <= 1'b0;
      comp_q    <= 1'b0;
    end else begin
      comp_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (start_edge) begin
          state_q   <= ST_START;
          bit_cnt_q <= '0;
          shift_q   <= '0;
          par_bit_q <= 1'b0;
          par_err_q <= 1'b0;
          frm_err_q <= 1'b0;
          brk_q     <= 1'b0;
        end
        ST_START: if (samp_hi) begin
          if (maj) state_q <= ST_IDLE;
          else     state_q <= ST_DATA;
        end
        ST_DATA: if (samp_hi) begin
          shift_q[bit_cnt_q] <= maj;
          if (bit_cnt_q == last_bit) begin
            if (par_en_q) state_q <= ST_PARITY;
            else          state_q <= ST_STOP1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: if (samp_hi) begin
          par_bit_q <= maj;
          par_err_q <= maj ^ (^shift_q) ^ par_odd_q;
          state_q   <= ST_STOP1;
        end
        ST_STOP1: if (samp_hi) begin
          if (!maj && (shift_q == 8'd0) && !(par_en_q && par_bit_q)) begin
            brk_q     <= 1'b1;
            frm_err_q <= 1'b1;
            comp_q    <= 1'b1;
            state_q   <= ST_BRKWAIT;
          end else begin
            frm_err_q <= !maj;
            if (stop2_q) begin
              state_q <= ST_STOP2;
            end else begin
              comp_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_STOP2: if (samp_hi) begin
          frm_err_q <= frm_err_q | !maj;
          comp_q    <= 1'b1;
          state_q   <= ST_IDLE;
        end
        ST_BRKWAIT: if (samp_hi && maj) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Single-entry holding register; a completion that cannot load is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_valid_o   <= 1'b0;
      rx_data_o    <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (comp_q && (!rx_valid_o || rx_ready_i)) begin
        rx_valid_o   <= 1'b1;
        rx_data_o    <= shift_q;
        parity_err_o <= par_err_q;
        frame_err_o  <= frm_err_q;
        break_o      <= brk_q;
      end else begin
        if (comp_q) overrun_o <= 1'b1;
        if (rx_valid_o && rx_ready_i) begin
          rx_valid_o   <= 1'b0;
          parity_err_o <= 1'b0;
          frame_err_o  <= 1'b0;
          break_o      <= 1'b0;
        end
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CHARS * 12 + 1);
  logic [TO_W-1:0] to_cnt_q, to_limit;

  assign to_limit   = TO_W'(TIMEOUT_CHARS * int'(uart_frame_bits(bits_q, par_en_q, stop2_q)));
  assign unused_sig = tick;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_cnt_q  <= '0;
      timeout_o <= 1'b0;
    end else if (start_edge || (rx_valid_o && rx_ready_i)) begin
      to_cnt_q  <= '0;
      timeout_o <= 1'b0;
    end else if (rx_valid_o && (state_q == ST_IDLE) && bit_end && !timeout_o) begin
      to_cnt_q <= to_cnt_q + 1'b1;
      if (to_cnt_q + 1'b1 == to_limit) timeout_o <= 1'b1;
    end
  end
`else
  assign timeout_o  = 1'b0;
  assign unused_sig = tick ^ bit_end ^ (TIMEOUT_CHARS != 0);
`endif

endmodule

// File: doc/uart_rx_ovs.md
Name: uart_rx_ovs

Overview:
- Next-generation UART receive core: oversampling receiver with majority-vote sampling, glitch-rejecting start detection, and programmable frame format.
- Reports per-character parity, framing, break, overrun and character-timeout status.
- Sits between the pad-side `rx_i` and an RX FIFO or APB register front-end.
- Fills the slots the current receiver ties off: character timeout indication, break, framing and odd parity.

Parameters:
- OVS, 16: oversampling ticks per bit; legal range 8..32, must be even.
- DIV_W, 16: width of the baud divisor.
- SYNC_STAGES, 2: flops in the `rx_i` synchronizer; minimum 2.
- TIMEOUT_CHARS, 4: idle character times before `timeout_o` asserts.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- rx_i  in  1  serial input, asynchronous to CLK
- cfg_div_i  in  DIV_W  oversample tick period minus 1
- cfg_bits_i  in  2  data bits: 0 = 5, 1 = 6, 2 = 7, 3 = 8
- cfg_parity_en_i  in  1  parity bit present
- cfg_parity_odd_i  in  1  1 = odd parity, 0 = even parity
- cfg_stop2_i  in  1  1 = two stop bits checked
- rx_data_o  out  8  received character, zero-extended above cfg_bits
- rx_valid_o  out  1  holding register full
- rx_ready_i  in  1  consumer accepts character
- parity_err_o  out  1  parity flag of the held character
- frame_err_o  out  1  framing flag of the held character
- break_o  out  1  held character is a break
- overrun_o  out  1  one-cycle pulse: character lost
- timeout_o  out  1  character-timeout indication (level)
- busy_o  out  1  frame in progress

Behaviour:
- Reset: all outputs 0; synchronizer flops reset to 1 (idle line); FSM in IDLE.
- Tick generator:
  - Counter runs 0..cfg_div_i; tick is asserted in the cycle count == cfg_div_i, then the counter returns to 0.
  - cfg_div_i = 0 gives a tick every cycle.
  - Counter free-runs in IDLE and restarts at 0 on start-edge detection.
- Sampling:
  - Bit value = majority of the synchronized input at tick indices OVS/2-1, OVS/2 and OVS/2+1 within the bit.
  - Tick index wraps at OVS-1.
- Config capture: cfg_* inputs are latched at start-edge detection; changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT.
- FSM transitions:
  - IDLE -> START on synchronized falling edge.
  - START: if the majority value is 1, return to IDLE with no flag (glitch reject); otherwise go to DATA.
  - DATA: bits captured LSB-first until (5 + cfg_bits) bits received.
  - After DATA, go to PARITY if parity is enabled, else STOP1.
  - PARITY: compare the received bit with the XOR of the data bits, XORed with cfg_parity_odd.
  - STOP1 -> STOP2 if cfg_stop2; otherwise the character completes.
  - In STOP1 and STOP2, a 0 sample sets the frame error.
- Completion timing: the character completes at the mid-sample of the last stop bit; the holding register loads in the following cycle. Sampling latency is therefore OVS/2+1 ticks after the last stop bit edge, plus 1 clk.
- Break:
  - Break is flagged when all data bits, parity and the stop bit are 0.
  - A break sets break_o = 1 and frame_err_o = 1, with rx_data_o = 0.
  - FSM then enters BRKWAIT and stays there until a majority-1 sample, then goes to IDLE. No further characters are produced during BRKWAIT.
- Holding register and handshake:
  - One entry.
  - `rx_valid_o` stays high until the cycle in which rx_valid_o & rx_ready_i; it drops the next cycle.
  - On a new completion while valid and not accepted: the old character and its flags are kept, `overrun_o` pulses for 1 cycle, and the new character is dropped.
  - Completion in the same cycle as acceptance: the new character loads and there is no overrun.
- Error flags: all flags are registered together with the data and clear on acceptance.
- busy_o: high from START through the last stop bit and throughout BRKWAIT.
- Timeout:
  - While rx_valid_o = 1 and FSM = IDLE, a bit-period counter runs.
  - Threshold = TIMEOUT_CHARS × (1 + 5 + cfg_bits + parity_en + 1 + stop2) bit periods, using the latched config.
  - `timeout_o` asserts on reaching the threshold and saturates.
  - Counter and `timeout_o` clear on acceptance or a start edge.
- Reset mid-frame: immediate return to reset state; a partial character is discarded.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined: timeout counter and `timeout_o` behave as above.
- Undefined: counter logic is removed and `timeout_o` is tied to 0; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum `uart_rx_state_e`;
  - the bits-encoding constants (`UART_BITS_5`..`UART_BITS_8`);
  - a function `uart_frame_bits(bits, par, stop2)` returning the frame length.
- One sub-module: `uart_baud_tick`, which contains the divisor counter and tick index, with restart input, tick output and mid-sample strobes.

Test Plan:
- Idle-to-receive: cfg_div = 3, OVS = 16, 8N1; send 0xA5 with rx_ready held 1 -> rx_data_o = 0xA5, rx_valid_o high for 1 cycle, no flags.
- Parity: 7O1 (cfg_bits = 2, odd); send 0x41 with the correct parity bit (1) -> no flag; resend with the parity bit flipped -> parity_err_o = 1 together with data 0x41.
- Framing and break: 8N2 with a second stop bit of 0 -> frame_err_o = 1; hold rx_i low for 2 frames -> break_o = 1, rx_data_o = 0x00, busy_o stays high until rx_i returns to 1.
- Overrun: rx_ready = 0; send 0x11 then 0x22 -> overrun_o pulses 1 cycle and the held value remains 0x11; raise ready in the completion cycle of a third character -> it loads with no overrun.
- Glitch reject: low pulse of 3 ticks on rx_i -> no character, busy_o returns to 0 at mid-start.
- Timeout (UART_RX_TIMEOUT_EN defined): 8N1, TIMEOUT_CHARS = 4, one character held unread -> timeout_o rises after 40 bit periods and falls the cycle after acceptance; with the macro undefined, timeout_o stays 0.
